mulby255: RTL and testbench
===========================

Name: mulby255

Overview:
- Inverse companion to the Divby255 divider: computes the exact product P = X * 255 for a 32-bit operand X. 255 = 2^8 - 1, so P = (X << 8) - X.
- Uses the same 16-bit-bus, flag-driven protocol as the divider. The operand is loaded in MSB and LSB halves, a start flag launches the calculation, and the 40-bit result is read back one 16-bit slice at a time.
- Computes byte-serially, one byte per clock, with a borrow chain. Used to round-trip check divider results and to scale counts by 255.

Parameters:
- BUS_W, 16, width of the data bus. Fixed; other values are unsupported.
- OP_W, 32, operand width. Must equal 2*BUS_W.
- RES_W, 40, result width. Must equal OP_W+8.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-low. rst=0 clears all state immediately.
- x  input  16  operand half supplied for a load.
- ld_msb  input  1  when high, the next edge loads X[31:16] from x.
- ld_lsb  input  1  when high, the next edge loads X[15:0] from x.
- start  input  1  when high, the next edge begins a multiply of the held X.
- sel  input  2  read-back select: 0 = P[15:0], 1 = P[31:16], 2 = {8'h00, P[39:32]}, 3 = 16'h0000.
- y  output  16  the result slice chosen by sel.
- busy  output  1  high while a calculation is in progress.
- done  output  1  high while the result register holds a valid product.

Behaviour:
- Reset (rst=0, asynchronous):
  - operand register X = 0 and result register P = 0;
  - borrow = 0 and byte index = 0;
  - FSM goes to IDLE; busy = 0, done = 0.
  - y therefore reads 0 for every sel value.
- FSM states:
  - IDLE, DONE: loads are accepted. start is accepted only if neither ld_msb nor ld_lsb is high in the same cycle; if they are, the load wins and start is dropped.
  - On an accepted start:
    - P <= 0, byte index <= 0, borrow <= 0, done <= 0;
    - FSM goes to CALC and busy goes to 1.
  - CALC: each edge computes result byte i, for i = 0..4:
    - a_i = X byte i-1 (with a_0 = 0);
    - b_i = X byte i (with b_4 = 0);
    - {borrow, P[8i+7:8i]} <= a_i - b_i - borrow;
    - after i = 4 the FSM goes to DONE, busy <= 0, done <= 1.
  - The final borrow is always 0, because (X<<8) >= X. Verification asserts this.
- Latency:
  - start is sampled at edge E; busy is high after edges E .. E+4.
  - P is complete and done = 1 after edge E+5.
- Inputs during CALC:
  - ld_msb, ld_lsb and start are ignored.
  - The operand X is held stable for the whole calculation.
- done clears on the next accepted start, or on any load accepted in DONE. The old P stays readable on y until a new start clears it.
- ld_msb and ld_lsb high in the same cycle: both halves load from the same x value.
- y is a combinational mux of P by sel, with no added latency. Partial P bytes are visible during CALC; consumers must qualify reads with done.
- Reset asserted mid-CALC: the calculation aborts immediately and all state returns to reset values. The operand is not retained.

Decomposition:
- Package mulby255_pkg holds:
  - the state enum {IDLE, CALC, DONE};
  - constants SEL_LSB = 0, SEL_MID = 1, SEL_TOP = 2;
  - NBYTES = 5, the number of result bytes.
- Sub-module sub8_borrow: a combinational 8-bit subtract with inputs a, b, bin and outputs d, bout. It is instantiated once and driven by the byte mux in CALC.
- The FSM, operand/result registers and output mux live in mulby255.

Test Plan:
- Load MSB = 16'h0000, LSB = 16'h00FF, start; wait for done. Expect the six-cycle latency above and busy high for exactly 5 cycles. Expect sel=0 -> 16'hFE01, sel=1 -> 16'h0000, sel=2 -> 16'h0000.
- Load 25500: MSB = 16'h0000, LSB = 16'h639C; start. Expect sel=0 -> 16'h3864, sel=1 -> 16'h0063, sel=2 -> 16'h0000.
- Load 16'hFFFF into both halves using a single cycle with ld_msb = ld_lsb = 1; start. Expect sel=0 -> 16'hFF01, sel=1 -> 16'hFFFF, sel=2 -> 16'h00FE, sel=3 -> 16'h0000. Expect the final borrow = 0.
- Round trip of the divider test value 2550: load MSB = 16'h0000, LSB = 16'h09F6; start. Expect P = 40'h0009_EC0A.
- During CALC of the 2550 case, pulse ld_lsb with x = 16'h1234 and pulse start. Expect both ignored and the result still 40'h0009_EC0A.
- Start the 16'hFFFF_FFFF case, then assert rst=0 two cycles after start. Expect busy = 0, done = 0 and y = 0 immediately. After release and a new start with no loads (X = 0), expect P = 0 and done after 6 cycles.

Source files
------------

// File: rtl/mulby255_pkg.sv
// Shared types and constants for the byte-serial multiply-by-255 unit.
// Operand byte selection helper is common to the datapath byte mux.
package mulby255_pkg;

  localparam int BUS_W  = 16;
  localparam int OP_W   = 2 * BUS_W;
  localparam int RES_W  = OP_W + 8;
  localparam int NBYTES = 5;

  localparam logic [1:0] SEL_LSB = 2'd0;
  localparam logic [1:0] SEL_MID = 2'd1;
  localparam logic [1:0] SEL_TOP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte i of the operand; indices past the top byte read as zero.
  function automatic logic [7:0] op_byte(input logic [OP_W-1:0] op, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = op[7:0];
      3'd1:    b = op[15:8];
      3'd2:    b = op[23:16];
      3'd3:    b = op[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mulby255_sub8_borrow.sv
// Combinational 8-bit subtractor with borrow in/out: {bout, d} = a - b - bin.
module sub8_borrow (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] d,
  output logic       bout
);

  assign {bout, d} = {1'b0, a} - {1'b0, b} - {8'h00, bin};

endmodule

// File: rtl/mulby255.sv
// Exact X*255 as (X<<8) - X, one result byte per clock through a borrow chain.
// 16-bit load/start/select bus protocol shared with the divide-by-255 block.
module mulby255
  import mulby255_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] x,
  input  logic             ld_msb,
  input  logic             ld_lsb,
  input  logic             start,
  input  logic [1:0]       sel,
  output logic [BUS_W-1:0] y,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  state_t           state;
  logic [OP_W-1:0]  op_x;
  logic [RES_W-1:0] prod;
  logic             borrow;
  logic [2:0]       byte_idx;

  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic [7:0] diff;
  logic       bout;

  // Byte mux: minuend is the shifted operand (byte i-1), subtrahend is byte i.
  always_comb begin
    a_byte = 8'h00;
    b_byte = op_byte(op_x, byte_idx);
    if (byte_idx == 3'd0) begin
      a_byte = 8'h00;
    end else begin
      a_byte = op_byte(op_x, byte_idx - 3'd1);
    end
  end

  sub8_borrow u_sub (
    .a    (a_byte),
    .b    (b_byte),
    .bin  (borrow),
    .d    (diff),
    .bout (bout)
  );

  // Control FSM plus operand, result and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      op_x     <= '0;
      prod     <= '0;
      borrow   <= 1'b0;
      byte_idx <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ld_msb || ld_lsb) begin
            if (ld_msb) op_x[OP_W-1:BUS_W] <= x;
            if (ld_lsb) op_x[BUS_W-1:0]    <= x;
            done  <= 1'b0;
            state <= IDLE;
          end else if (start) begin
            prod     <= '0;
            byte_idx <= 3'd0;
            borrow   <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end else begin
            state <= state;
          end
        end
        CALC: begin
          case (byte_idx)
            3'd0:    prod[7:0]   <= diff;
            3'd1:    prod[15:8]  <= diff;
            3'd2:    prod[23:16] <= diff;
            3'd3:    prod[31:24] <= diff;
            3'd4:    prod[39:32] <= diff;
            default: prod        <= prod;
          endcase
          borrow <= bout;
          if (byte_idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            byte_idx <= byte_idx + 3'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Read-back slice; partial bytes are visible while busy.
  always_comb begin
    y = 16'h0000;
    case (sel)
      SEL_LSB: y = prod[15:0];
      SEL_MID: y = prod[31:16];
      SEL_TOP: y = {8'h00, prod[39:32]};
      default: y = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_mulby255.sv
// Self-checking bench for mulby255: directed cases from the datasheet plus
// random operands compared against a plain X*255 arithmetic model.
module tb_mulby255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x = 16'h0000;
  logic        ld_msb = 1'b0;
  logic        ld_lsb = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] y;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  mulby255 dut (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .ld_msb (ld_msb),
    .ld_lsb (ld_lsb),
    .start  (start),
    .sel    (sel),
    .y      (y),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic m, input logic l, input logic [15:0] v);
    ld_msb = m; ld_lsb = l; x = v;
    @(posedge clk); #1;
    ld_msb = 1'b0; ld_lsb = 1'b0; x = 16'h0000;
  endtask

  // Pulse start, then count edges until done (bounded); lat counts edge E as 1.
  task automatic run(output int lat, output int busy_cnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  // Reads all four slices as {sel2, sel1, sel0}; sel3 is returned separately.
  task automatic read_all(output logic [47:0] r, output logic [15:0] s3);
    sel = 2'd0; #1 r[15:0]  = y;
    sel = 2'd1; #1 r[31:16] = y;
    sel = 2'd2; #1 r[47:32] = y;
    sel = 2'd3; #1 s3       = y;
    sel = 2'd0;
  endtask

  function automatic logic [47:0] model(input logic [31:0] xv);
    logic [39:0] p;
    p = {8'h00, xv} * 40'd255;
    return {8'h00, p};
  endfunction

  initial begin
    int lat, bc;
    logic [47:0] r;
    logic [15:0] s3;
    logic [31:0] xv;

    // Reset state
    #12;
    chk("rst_busy", {47'd0, busy}, 48'd0);
    chk("rst_done", {47'd0, done}, 48'd0);
    read_all(r, s3);
    chk("rst_y", r, 48'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 0x000000FF: latency and busy width
    load(1'b1, 1'b0, 16'h0000);
    load(1'b0, 1'b1, 16'h00FF);
    run(lat, bc);
    chk("ff_latency", 48'(lat), 48'd6);
    chk("ff_busy_cycles", 48'(bc), 48'd5);
    read_all(r, s3);
    chk("ff_result", r, {16'h0000, 16'h0000, 16'hFE01});

    // 25500
    load(1'b1, 1'b0, 16'h0000);
    load(1'b0, 1'b1, 16'h639C);
    run(lat, bc);
    read_all(r, s3);
    chk("d25500_result", r, {16'h0000, 16'h0063, 16'h3864});

    // Load in DONE clears done, old P stays readable
    load(1'b1, 1'b1, 16'hFFFF);
    chk("load_clears_done", {47'd0, done}, 48'd0);
    read_all(r, s3);
    chk("old_p_kept", r, {16'h0000, 16'h0063, 16'h3864});

    // 0xFFFFFFFF via a dual load
    run(lat, bc);
    chk("ffff_latency", 48'(lat), 48'd6);
    read_all(r, s3);
    chk("ffff_result", r, {16'h00FE, 16'hFFFF, 16'hFF01});
    chk("ffff_sel3", {32'd0, s3}, 48'd0);
    chk("ffff_borrow", {47'd0, dut.borrow}, 48'd0);

    // 2550 with loads and start poked during CALC
    load(1'b1, 1'b0, 16'h0000);
    load(1'b0, 1'b1, 16'h09F6);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("calc_busy", {47'd0, busy}, 48'd1);
    ld_lsb = 1'b1; x = 16'h1234; start = 1'b1;
    @(posedge clk); #1;
    ld_lsb = 1'b0; x = 16'h0000; start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("poke_latency", 48'(lat), 48'd6);
    read_all(r, s3);
    chk("d2550_result", r, {8'h00, 40'h0009_EC0A});

    // Reset mid-calculation
    load(1'b1, 1'b1, 16'hFFFF);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_busy", {47'd0, busy}, 48'd0);
    chk("midrst_done", {47'd0, done}, 48'd0);
    read_all(r, s3);
    chk("midrst_y", r, 48'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run(lat, bc);
    chk("post_rst_latency", 48'(lat), 48'd6);
    read_all(r, s3);
    chk("post_rst_zero", r, 48'd0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      xv = $urandom;
      if (i % 3 == 0) begin
        load(1'b0, 1'b1, xv[15:0]);
        load(1'b1, 1'b0, xv[31:16]);
      end else begin
        load(1'b1, 1'b0, xv[31:16]);
        load(1'b0, 1'b1, xv[15:0]);
      end
      run(lat, bc);
      chk("rand_latency", 48'(lat), 48'd6);
      chk("rand_busy_cycles", 48'(bc), 48'd5);
      read_all(r, s3);
      chk("rand_result", r, model(xv));
      chk("rand_sel3", {32'd0, s3}, 48'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
